// File: rtl/puf_soc_sipo_arb_if.sv
// Signal bundle between the two serial requesters, the arbiter and the shared
// SIPO deserializer; the arbiter uses the slave view, the environment the master view.
interface puf_soc_sipo_arb_if #(
    parameter int LEN_W = 16
);
    logic [1:0]       i_req;
    logic [LEN_W-1:0] i_len0;
    logic [LEN_W-1:0] i_len1;
    logic [1:0]       i_bit;
    logic [1:0]       i_bit_valid;
    logic [1:0]       o_bit_ready;
    logic [1:0]       o_grant;
    logic [1:0]       o_done;
    logic             o_partial;
    logic             o_busy;
    logic             o_sipo_valid;
    logic             o_sipo_data;
    logic             i_sipo_ready;

    modport master (
        output i_req, i_len0, i_len1, i_bit, i_bit_valid, i_sipo_ready,
        input  o_bit_ready, o_grant, o_done, o_partial, o_busy, o_sipo_valid, o_sipo_data
    );

    modport slave (
        input  i_req, i_len0, i_len1, i_bit, i_bit_valid, i_sipo_ready,
        output o_bit_ready, o_grant, o_done, o_partial, o_busy, o_sipo_valid, o_sipo_data
    );
endinterface

// File: rtl/puf_soc_sipo_arb.sv
// Round-robin arbiter/sequencer sharing one SIPO deserializer between two serial requesters.
// Optional PUF_SOC_SIPO_ARB_PAD_EN: zero-pad short packets up to a whole N_BIT word.
module puf_soc_sipo_arb #(
    parameter int N_BIT = 32,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    puf_soc_sipo_arb_if.slave bus
);
    localparam int WP_W = $clog2(N_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_STREAM,
`ifdef PUF_SOC_SIPO_ARB_PAD_EN
        S_PAD,
`endif
        S_DONE
    } state_t;

    // Where a packet goes once its data is over and the word is not yet full.
`ifdef PUF_SOC_SIPO_ARB_PAD_EN
    localparam state_t S_TAIL = S_PAD;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state_reg, state_next;
    logic              gsel_reg, gsel_next;
    logic              ptr_reg, ptr_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [WP_W-1:0]   word_pos_reg, word_pos_next;
    logic [LEN_W-1:0]  len_sel;
    logic [1:0]        bit_ready;
    logic [1:0]        done;
    logic              partial;
    logic              sipo_valid;
    logic              sipo_data;

    assign len_sel = gsel_reg ? bus.i_len1 : bus.i_len0;

    // ptr_reg holds the last requester served; resetting it to 1 makes requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            gsel_reg     <= 1'b0;
            ptr_reg      <= 1'b1;
            len_reg      <= '0;
            bit_cnt_reg  <= '0;
            word_pos_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gsel_reg     <= gsel_next;
            ptr_reg      <= ptr_next;
            len_reg      <= len_next;
            bit_cnt_reg  <= bit_cnt_next;
            word_pos_reg <= word_pos_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gsel_next     = gsel_reg;
        ptr_next      = ptr_reg;
        len_next      = len_reg;
        bit_cnt_next  = bit_cnt_reg;
        word_pos_next = word_pos_reg;
        bit_ready     = 2'b00;
        done          = 2'b00;
        partial       = 1'b0;
        sipo_valid    = 1'b0;
        sipo_data     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.i_req != 2'b00) begin
                    gsel_next  = (bus.i_req == 2'b11) ? ~ptr_reg : bus.i_req[1];
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                len_next      = len_sel;
                bit_cnt_next  = '0;
                word_pos_next = '0;
                state_next    = (len_sel == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (!bus.i_req[gsel_reg]) begin
                    state_next = (word_pos_reg != '0) ? S_TAIL : S_DONE;
                end else begin
                    sipo_valid          = bus.i_bit_valid[gsel_reg];
                    sipo_data           = bus.i_bit[gsel_reg];
                    bit_ready[gsel_reg] = bus.i_sipo_ready;
                    if (sipo_valid && bus.i_sipo_ready) begin
                        bit_cnt_next  = bit_cnt_reg + 1'b1;
                        word_pos_next = word_pos_reg + 1'b1;
                        // Compare the incremented count so len = 2^LEN_W-1 never wraps.
                        if (bit_cnt_next == len_reg) begin
                            state_next = (word_pos_next != '0) ? S_TAIL : S_DONE;
                        end
                    end
                end
            end
`ifdef PUF_SOC_SIPO_ARB_PAD_EN
            S_PAD: begin
                sipo_valid = 1'b1;
                sipo_data  = 1'b0;
                if (bus.i_sipo_ready) begin
                    word_pos_next = word_pos_reg + 1'b1;
                    if (word_pos_next == '0) begin
                        state_next = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                done[gsel_reg] = 1'b1;
`ifndef PUF_SOC_SIPO_ARB_PAD_EN
                partial        = (word_pos_reg != '0);
`endif
                ptr_next       = gsel_reg;
                state_next     = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.o_bit_ready  = bit_ready;
    assign bus.o_done       = done;
    assign bus.o_partial    = partial;
    assign bus.o_sipo_valid = sipo_valid;
    assign bus.o_sipo_data  = sipo_data;
    assign bus.o_busy       = (state_reg != S_IDLE);
    assign bus.o_grant      = (state_reg == S_IDLE) ? 2'b00 : (gsel_reg ? 2'b10 : 2'b01);
endmodule

// File: tb/tb_puf_soc_sipo_arb.sv
// Randomized bench for puf_soc_sipo_arb: packet-level reference model plus directed cases.
`timescale 1ns/1ps
module tb_puf_soc_sipo_arb;
    localparam int N_BIT = 32;
    localparam int LEN_W = 16;
    localparam int MAXL  = 160;
`ifdef PUF_SOC_SIPO_ARB_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puf_soc_sipo_arb_if #(.LEN_W(LEN_W)) sif();

    puf_soc_sipo_arb #(.N_BIT(N_BIT), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Packet descriptors per requester
    int  pk_len   [2];
    int  pk_abort [2];
    bit  pk_bits  [2][MAXL];
    int  idx      [2];
    bit  pend     [2];
    bit  seen_grant [2];
    int  p_valid = 100;
    int  p_ready = 100;

    // Results of the most recent completed packet, recorded by the checker
    int  last_done_cyc, last_count, last_first;
    bit  last_partial;
    int  done_order[$];

    // Packet-level reference model and per-cycle checker
    initial begin
        bit         prev_busy = 0, prev_done = 0, rr_last = 1;
        logic [1:0] prev_req = 2'b00;
        int         cur_g = 0, grant_cyc = 0, first_xfer = -1, last_xfer = -1;
        bit         cap_q[$];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 0; prev_done = 0; rr_last = 1; prev_req = 2'b00;
                cap_q.delete();
            end else begin
                if (sif.o_grant != 2'b00 && !prev_busy) begin
                    int win;
                    if (prev_req == 2'b11) win = rr_last ? 0 : 1;
                    else                   win = prev_req[1] ? 1 : 0;
                    chk(sif.o_grant == (2'b01 << win), "rr_winner", sif.o_grant, 2'b01 << win);
                    cur_g = win; grant_cyc = cyc; first_xfer = -1; last_xfer = -1;
                    cap_q.delete();
                end
                if (!prev_busy && prev_req != 2'b00)
                    chk(sif.o_grant != 2'b00, "grant_latency", sif.o_grant, 1);
                if (prev_done)
                    chk(!sif.o_busy, "done_to_idle", sif.o_busy, 0);
                chk(sif.o_busy == (sif.o_grant != 2'b00), "busy_vs_grant", sif.o_busy, sif.o_grant != 2'b00);
                chk(sif.o_grant != 2'b11, "grant_onehot", sif.o_grant, 1);
                chk((sif.o_bit_ready & ~sif.o_grant) == 2'b00, "ready_nongranted", sif.o_bit_ready, sif.o_grant);
                if (!sif.o_busy)
                    chk({sif.o_sipo_valid, sif.o_done, sif.o_partial} == 4'b0, "idle_quiet",
                        {sif.o_sipo_valid, sif.o_done, sif.o_partial}, 0);
                if (sif.o_bit_ready != 2'b00)
                    chk(sif.i_sipo_ready == 1'b1, "ready_passthru", sif.i_sipo_ready, 1);
                if (sif.o_busy && sif.o_bit_ready[cur_g])
                    chk(sif.o_sipo_valid == sif.i_bit_valid[cur_g] &&
                        (!sif.o_sipo_valid || sif.o_sipo_data == sif.i_bit[cur_g]), "data_passthru",
                        {sif.o_sipo_valid, sif.o_sipo_data}, {sif.i_bit_valid[cur_g], sif.i_bit[cur_g]});
                if (sif.o_busy && cyc == grant_cyc + 1 && pk_len[cur_g] != 0 && sif.i_req[cur_g])
                    chk(sif.o_bit_ready[cur_g] == sif.i_sipo_ready, "first_bit_window",
                        sif.o_bit_ready[cur_g], sif.i_sipo_ready);
                if (sif.o_sipo_valid && sif.i_sipo_ready) begin
                    cap_q.push_back(sif.o_sipo_data);
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                end
                if (sif.o_done != 2'b00) begin
                    int k, pad, exp_cyc, mism;
                    bit ab, eb;
                    chk(sif.o_done == sif.o_grant, "done_owner", sif.o_done, sif.o_grant);
                    ab  = pk_abort[cur_g] > 0 && pk_abort[cur_g] < pk_len[cur_g];
                    k   = ab ? pk_abort[cur_g] : pk_len[cur_g];
                    pad = PAD_EN ? (N_BIT - k % N_BIT) % N_BIT : 0;
                    chk(cap_q.size() == k + pad, "stream_len", cap_q.size(), k + pad);
                    mism = 0;
                    foreach (cap_q[i]) begin
                        eb = (i < k) ? pk_bits[cur_g][i] : 1'b0;
                        if (cap_q[i] != eb) mism++;
                    end
                    chk(mism == 0, "stream_bits", mism, 0);
                    chk(sif.o_partial == (!PAD_EN && (k % N_BIT) != 0), "partial",
                        sif.o_partial, !PAD_EN && (k % N_BIT) != 0);
                    if (k == 0)               exp_cyc = grant_cyc + 1;
                    else if (ab && pad == 0)  exp_cyc = last_xfer + 2;
                    else                      exp_cyc = last_xfer + 1;
                    chk(cyc == exp_cyc, "done_timing", cyc, exp_cyc);
                    last_done_cyc = cyc;
                    last_count    = cap_q.size();
                    last_first    = first_xfer;
                    last_partial  = sif.o_partial;
                    done_order.push_back(sif.o_done[1] ? 1 : 0);
                    rr_last = cur_g[0];
                end
                prev_done = (sif.o_done != 2'b00);
                prev_busy = sif.o_busy;
                prev_req  = sif.i_req;
            end
        end
    end

    // One requester/deserializer cycle: observe the handshake, then drive the next inputs.
    task automatic drive_cycle();
        logic [1:0] acc, dn, req_v, val_v, bit_v;
        @(negedge clk);
        acc = sif.i_bit_valid & sif.o_bit_ready;
        dn  = sif.o_done;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (pend[r]) begin
                if (acc[r]) idx[r]++;
                if (dn[r]) begin
                    pend[r] = 0;
                    seen_grant[r] = 0;
                end
            end
            req_v[r] = pend[r] && !(pk_abort[r] > 0 && idx[r] >= pk_abort[r]);
            val_v[r] = pend[r] && ($urandom_range(99) < p_valid);
            bit_v[r] = pk_bits[r][(idx[r] < MAXL) ? idx[r] : 0];
            if (seen_grant[r]) begin
                if (r == 0) sif.i_len0 = LEN_W'($urandom);
                else        sif.i_len1 = LEN_W'($urandom);
            end
            if (pend[r] && sif.o_grant[r]) seen_grant[r] = 1;
        end
        sif.i_req        = req_v;
        sif.i_bit_valid  = val_v;
        sif.i_bit        = bit_v;
        sif.i_sipo_ready = ($urandom_range(99) < p_ready);
    endtask

    task automatic start_pkt(input int r, input int len, input int ab);
        pk_len[r] = len; pk_abort[r] = ab; idx[r] = 0; pend[r] = 1; seen_grant[r] = 0;
        for (int i = 0; i < MAXL; i++) pk_bits[r][i] = 1'($urandom_range(1));
        if (r == 0) sif.i_len0 = LEN_W'(len);
        else        sif.i_len1 = LEN_W'(len);
        sif.i_req[r] = 1'b1;
        if (r == 0) sif.i_bit[0] = pk_bits[0][0];
        else        sif.i_bit[1] = pk_bits[1][0];
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pend[0] || pend[1]) && n < budget) begin
            drive_cycle();
            n++;
        end
        if (pend[0] || pend[1]) chk(1'b0, "idle_timeout", n, budget);
    endtask

    function automatic logic [9:0] outs_word();
        return {sif.o_grant, sif.o_done, sif.o_partial, sif.o_busy, sif.o_bit_ready,
                sif.o_sipo_valid, sif.o_sipo_data};
    endfunction

    initial begin
        int c0, sz;
        sif.i_req = 2'b00; sif.i_len0 = '0; sif.i_len1 = '0; sif.i_bit = 2'b00;
        sif.i_bit_valid = 2'b00; sif.i_sipo_ready = 1'b0;
        pend[0] = 0; pend[1] = 0; pk_len[0] = 0; pk_len[1] = 0; pk_abort[0] = 0; pk_abort[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk(outs_word() == 10'd0, "reset_outputs", outs_word(), 0);
        rst_n = 1'b1;

        // Both requesting straight out of reset, then both again
        start_pkt(0, 16, 0);
        start_pkt(1, 16, 0);
        wait_idle(500);
        start_pkt(0, 16, 0);
        start_pkt(1, 16, 0);
        wait_idle(500);
        sz = done_order.size();
        chk(sz == 4, "simul_count", sz, 4);
        if (sz == 4) begin
            chk(done_order[0] == 0, "simul_first", done_order[0], 0);
            chk(done_order[1] == 1, "simul_second", done_order[1], 1);
            chk(done_order[2] == 0, "simul_third", done_order[2], 0);
            chk(done_order[3] == 1, "simul_fourth", done_order[3], 1);
        end

        // Exact word
        c0 = cyc;
        start_pkt(0, 32, 0);
        wait_idle(500);
        chk(last_first - c0 == 2, "exact_first_bit", last_first - c0, 2);
        chk(last_done_cyc - c0 == 34, "exact_done_cyc", last_done_cyc - c0, 34);
        chk(last_count == 32, "exact_count", last_count, 32);

        // Short packet
        c0 = cyc;
        start_pkt(1, 40, 0);
        wait_idle(500);
        chk(last_count == (PAD_EN ? 64 : 40), "short_count", last_count, PAD_EN ? 64 : 40);
        chk(last_partial == !PAD_EN, "short_partial", last_partial, !PAD_EN);
        chk(last_done_cyc - c0 == (PAD_EN ? 66 : 42), "short_done_cyc", last_done_cyc - c0, PAD_EN ? 66 : 42);

        // Zero length
        c0 = cyc;
        start_pkt(0, 0, 0);
        wait_idle(500);
        chk(last_done_cyc - c0 == 2, "zero_done_cyc", last_done_cyc - c0, 2);
        chk(last_count == 0, "zero_count", last_count, 0);

        // Abort after 10 bits with a stalling deserializer
        p_ready = 50;
        start_pkt(0, 100, 10);
        wait_idle(2000);
        chk(last_count == (PAD_EN ? 32 : 10), "abort_count", last_count, PAD_EN ? 32 : 10);
        p_ready = 100;

        // Reset in the middle of a packet
        start_pkt(0, 100, 0);
        repeat (10) drive_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk(outs_word() == 10'd0, "async_reset", outs_word(), 0);
        pend[0] = 0; pend[1] = 0;
        sif.i_req = 2'b00; sif.i_bit_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = cyc;
        start_pkt(1, 8, 0);
        wait_idle(500);
        chk(last_first - c0 == 2, "post_reset_first_bit", last_first - c0, 2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                p_valid = $urandom_range(30, 100);
                p_ready = $urandom_range(30, 100);
            end
            drive_cycle();
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(9) == 0) begin
                    int len, ab;
                    len = $urandom_range(0, MAXL - 1);
                    ab  = (len >= 2 && $urandom_range(3) == 0) ? $urandom_range(1, len - 1) : 0;
                    start_pkt(r, len, ab);
                end
            end
        end
        wait_idle(5000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
